// File: rtl/mainbus_pkg.sv
// Shared types and constants for the JAM-1 main-bus transfer stage.
// Optional build macro used by this slice: MAINBUS_XFER_CNT_EN (adds xfer_count).
package mainbus_pkg;

  localparam int unsigned NUM_REGS_DEFAULT = 8;
  localparam int unsigned SEL_W_DEFAULT    = 3;
  // Select fields are stored at this fixed width so one entry type serves any SEL_W <= 8.
  localparam int unsigned SEL_W_MAX        = 8;
  localparam int unsigned DATA_W           = 8;

  localparam logic [DATA_W-1:0] BUS_IDLE = 8'h00;

  typedef struct packed {
    logic                 valid;
    logic                 src_imm;
    logic [SEL_W_MAX-1:0] src_sel;
    logic [DATA_W-1:0]    imm;
    logic [SEL_W_MAX-1:0] dst_sel;
  } xfer_entry_t;

endpackage

// File: rtl/mainbus_skid2.sv
// Two-entry skid buffer for main-bus transfer entries.
// Entry 0 is the head presented downstream; entry 1 catches an accept while the head is held.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push_valid   upstream offers push_data
//   push_data    entry to enqueue (valid field must be 1)
//   ready        registered; high when entry 1 is empty
//   pop          head retires at this edge
//   flush        clear both entries and drop any same-cycle push
//   head         entry 0
module mainbus_skid2
  import mainbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid,
  input  xfer_entry_t push_data,
  output logic        ready,
  input  logic        pop,
  input  logic        flush,
  output xfer_entry_t head
);

  xfer_entry_t e0_q, e1_q, e0_d, e1_d;
  logic        ready_q;
  logic        accept;

  assign accept = push_valid & ready_q;
  assign ready  = ready_q;
  assign head   = e0_q;

  // Next-state: flush wins, then pop/advance, then plain enqueue.
  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    if (flush) begin
      e0_d.valid = 1'b0;
      e1_d.valid = 1'b0;
    end else if (pop) begin
      if (e1_q.valid) begin
        e0_d       = e1_q;
        e1_d       = push_data;
        e1_d.valid = accept;
      end else begin
        e0_d       = push_data;
        e0_d.valid = accept;
      end
    end else if (accept) begin
      if (!e0_q.valid) e0_d = push_data;
      else             e1_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      ready_q <= 1'b1;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      ready_q <= ~e1_d.valid;
    end
  end

endmodule

// File: rtl/mainbus_xfer_stage.sv
// Main-bus transfer stage: buffers MOV-style transfers and drives the bus plus one
// active-low load strobe for the destination register during the commit cycle.
// Optional macro MAINBUS_XFER_CNT_EN adds a 16-bit count of strobing commits.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      transfer handshake (in_ready registered)
//   in_src_sel/in_src_imm/in_imm/in_dst_sel  transfer fields
//   stall, flush           hold / discard
//   reg_q_flat             register outputs, reg i at [8i+7:8i]
//   bus_out                main bus value
//   reg_load_n             active-low per-register load strobes
//   xfer_busy              head entry valid
//   xfer_count             (MAINBUS_XFER_CNT_EN only) strobing commit count
module mainbus_xfer_stage
  import mainbus_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned SEL_W    = SEL_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_src_sel,
  input  logic                  in_src_imm,
  input  logic [7:0]            in_imm,
  input  logic [SEL_W-1:0]      in_dst_sel,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [8*NUM_REGS-1:0] reg_q_flat,
  output logic [7:0]            bus_out,
  output logic [NUM_REGS-1:0]   reg_load_n,
`ifdef MAINBUS_XFER_CNT_EN
  output logic [15:0]           xfer_count,
`endif
  output logic                  xfer_busy
);

  xfer_entry_t push_data;
  xfer_entry_t head;
  logic        commit;
  logic        src_hit, dst_hit, src_ok, self_move, strobe;
  logic [7:0]  src_reg, src_val;
  logic [NUM_REGS-1:0] load_vec;

  always_comb begin
    push_data         = '0;
    push_data.valid   = 1'b1;
    push_data.src_imm = in_src_imm;
    push_data.src_sel = SEL_W_MAX'(in_src_sel);
    push_data.imm     = in_imm;
    push_data.dst_sel = SEL_W_MAX'(in_dst_sel);
  end

  // Commit is suppressed during reset so no strobe escapes in the reset cycle.
  assign commit = head.valid & ~stall & ~flush & ~rst;

  mainbus_skid2 u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_data  (push_data),
    .ready      (in_ready),
    .pop        (commit),
    .flush      (flush),
    .head       (head)
  );

  // Index decode by match loop: out-of-range selects simply never hit.
  always_comb begin
    src_hit = 1'b0;
    dst_hit = 1'b0;
    src_reg = BUS_IDLE;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (head.src_sel == SEL_W_MAX'(i)) begin
        src_hit = 1'b1;
        src_reg = reg_q_flat[8*i +: 8];
      end
      if (head.dst_sel == SEL_W_MAX'(i)) dst_hit = 1'b1;
    end
  end

  assign src_ok    = head.src_imm | src_hit;
  assign src_val   = head.src_imm ? head.imm : src_reg;
  assign self_move = ~head.src_imm & (head.src_sel == head.dst_sel);
  assign strobe    = commit & src_ok & dst_hit & ~self_move;

  always_comb begin
    load_vec = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (strobe && head.dst_sel == SEL_W_MAX'(i)) load_vec[i] = 1'b1;
    end
  end

  assign reg_load_n = ~load_vec;
  assign bus_out    = (head.valid & src_ok & dst_hit & ~rst) ? src_val : BUS_IDLE;
  assign xfer_busy  = head.valid;

`ifdef MAINBUS_XFER_CNT_EN
  // Counts only commits that actually pulse a strobe; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)         xfer_count <= 16'h0000;
    else if (strobe) xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule
